// File: rtl/tank_ctrl_pkg.sv
// Shared types and constants for the tank fill controller.
// Holds the FSM state encoding, lamp codes and small elaboration helpers.
package tank_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [3:0] LAMP_FULL  = 4'b1010;
  localparam logic [3:0] LAMP_EMPTY = 4'b0101;
  localparam logic [3:0] LAMP_PART  = 4'b0110;
  localparam logic [3:0] LAMP_FAULT = 4'b1111;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Fault overrides the probe display; otherwise the code follows {bot,top}.
  function automatic logic [3:0] lamp_code(input state_t st, input logic bot, input logic top);
    logic [3:0] code;
    if (st == ST_FAULT) begin
      code = LAMP_FAULT;
    end else begin
      case ({bot, top})
        2'b11:   code = LAMP_FULL;
        2'b00:   code = LAMP_EMPTY;
        default: code = LAMP_PART;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/probe_debounce.sv
// Two-flop synchroniser followed by a consecutive-disagreement debounce counter.
// db_nxt_o is the value the debounced register takes on the coming edge.
module probe_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_nxt_o
);

  localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
      // DEBOUNCE-th consecutive disagreeing sample: accept the new level.
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_nxt_o = db_d;

endmodule

// File: rtl/tank_fill_controller.sv
// Hysteretic pump sequencer for a two-probe tank with anti-short-cycle timers.
// Optional fill watchdog in ON is enabled by defining FILL_TIMEOUT_EN.
module tank_fill_controller
  import tank_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int MIN_ON   = 8,
  parameter int MIN_OFF  = 8,
  parameter int MAX_FILL = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Bot,
  input  logic       Top,
  input  logic       clr_fault,
  output logic       pump,
  output logic       fault,
  output logic [3:0] lamp
);

  localparam int TMR_W = $clog2(max4(DEBOUNCE, MIN_ON, MIN_OFF, MAX_FILL)) + 1;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               bot_db_d, top_db_d;
  logic               incons;
  logic               pump_q, fault_q;
  logic [3:0]         lamp_q;

  probe_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_bot (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (Bot),
    .db_nxt_o (bot_db_d)
  );

  probe_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_top (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (Top),
    .db_nxt_o (top_db_d)
  );

  // Decisions use the debounced values being loaded this edge, so a probe
  // change and the resulting state change land on the same edge.
  assign incons = top_db_d && !bot_db_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (incons)
          state_d = ST_FAULT;
        else if (!bot_db_d && (tmr_q >= TMR_W'(MIN_OFF)))
          state_d = ST_ON;
      end
      ST_ON: begin
        if (incons)
          state_d = ST_FAULT;
        else if (top_db_d && (tmr_q >= TMR_W'(MIN_ON)))
          state_d = ST_OFF;
`ifdef FILL_TIMEOUT_EN
        else if (tmr_q >= TMR_W'(MAX_FILL - 1))
          state_d = ST_FAULT;
`endif
      end
      ST_FAULT: begin
        if (clr_fault && !incons)
          state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q)
      tmr_d = '0;
    else if (tmr_q != {TMR_W{1'b1}})
      tmr_d = tmr_q + TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      tmr_q   <= '0;
      pump_q  <= 1'b0;
      fault_q <= 1'b0;
      lamp_q  <= LAMP_EMPTY;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pump_q  <= (state_d == ST_ON);
      fault_q <= (state_d == ST_FAULT);
      lamp_q  <= lamp_code(state_d, bot_db_d, top_db_d);
    end
  end

  assign pump  = pump_q;
  assign fault = fault_q;
  assign lamp  = lamp_q;

endmodule

// File: tb/tb_tank_fill_controller.sv
// Directed bench for tank_fill_controller at default parameters.
// Expectations follow FILL_TIMEOUT_EN when the macro is defined for the build.
module tb_tank_fill_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       Bot, Top, clr_fault;
  logic       pump, fault;
  logic [3:0] lamp;

  int n_tests = 0;
  int n_fail  = 0;

  tank_fill_controller dut (
    .clk       (clk),
    .rst       (rst),
    .Bot       (Bot),
    .Top       (Top),
    .clr_fault (clr_fault),
    .pump      (pump),
    .fault     (fault),
    .lamp      (lamp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic p, input logic f, input logic [3:0] l);
    check({tag, ".pump"},  32'(pump),  32'(p));
    check({tag, ".fault"}, 32'(fault), 32'(f));
    check({tag, ".lamp"},  32'(lamp),  32'(l));
  endtask

  task automatic startup_seq(input string tag);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check_outs({tag, ".wait"}, 1'b0, 1'b0, 4'b0101);
    end
    tick(1);
    check_outs({tag, ".start"}, 1'b1, 1'b0, 4'b0101);
  endtask

  initial begin
    rst = 1'b1; Bot = 1'b0; Top = 1'b0; clr_fault = 1'b0;
    tick(2);
    check_outs("reset", 1'b0, 1'b0, 4'b0101);
    rst = 1'b0;

    // Empty tank: MIN_OFF holds the pump off for 8 edges.
    startup_seq("t1");

    // Bot rises: partial after 2+DEBOUNCE edges, pump keeps running.
    Bot = 1'b1;
    tick(5);
    check_outs("t2.bot_pre", 1'b1, 1'b0, 4'b0101);
    tick(1);
    check_outs("t2.bot", 1'b1, 1'b0, 4'b0110);
    Top = 1'b1;
    tick(5);
    check_outs("t2.top_pre", 1'b1, 1'b0, 4'b0110);
    tick(1);
    check_outs("t2.full", 1'b0, 1'b0, 4'b1010);

    // Short glitches never reach the debounced values.
    Top = 1'b0;
    tick(3);
    Top = 1'b1;
    tick(2);
    check_outs("t3.top_glitch", 1'b0, 1'b0, 4'b1010);
    tick(6);
    check_outs("t3.top_settle", 1'b0, 1'b0, 4'b1010);
    Bot = 1'b0;
    tick(3);
    Bot = 1'b1;
    tick(2);
    check_outs("t3.bot_glitch", 1'b0, 1'b0, 4'b1010);
    tick(6);
    check_outs("t3.bot_settle", 1'b0, 1'b0, 4'b1010);

    // Top wet with Bot dry -> FAULT.
    Bot = 1'b0;
    tick(5);
    check_outs("t4.pre", 1'b0, 1'b0, 4'b1010);
    tick(1);
    check_outs("t4.fault", 1'b0, 1'b1, 4'b1111);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    check_outs("t4.clr_incons", 1'b0, 1'b1, 4'b1111);
    Bot = 1'b1;
    tick(6);
    check_outs("t4.consistent", 1'b0, 1'b1, 4'b1111);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    check_outs("t4.cleared", 1'b0, 1'b0, 4'b1010);
    tick(8);
    check_outs("t4.off_hold", 1'b0, 1'b0, 4'b1010);

    // Drain both probes together; OFF timer already past MIN_OFF.
    Bot = 1'b0; Top = 1'b0;
    tick(5);
    check_outs("drain.pre", 1'b0, 1'b0, 4'b1010);
    tick(1);
    check_outs("drain.on", 1'b1, 1'b0, 4'b0101);
    tick(3);
    check_outs("t6.midfill", 1'b1, 1'b0, 4'b0101);

    // Reset mid-fill, then the start-up sequence repeats.
    rst = 1'b1;
    tick(1);
    check_outs("t6.reset", 1'b0, 1'b0, 4'b0101);
    rst = 1'b0;
    startup_seq("t6");

`ifdef FILL_TIMEOUT_EN
    tick(63);
    check_outs("t5.wd_pre", 1'b1, 1'b0, 4'b0101);
    tick(1);
    check_outs("t5.wd_fault", 1'b0, 1'b1, 4'b1111);
`else
    tick(100);
    check_outs("t5.no_wd", 1'b1, 1'b0, 4'b0101);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
